// File: rtl/arp_request_if.sv
// Handshake bundle for arp_request: resolution request/result plus the byte-wide
// MAC RX and TX streams. The slave modport is the arp_request side.
interface arp_request_if;
   logic        req_start;
   logic [31:0] req_ipv4;
   logic        req_busy;
   logic        resolved_valid;
   logic [47:0] resolved_mac;
   logic        timeout;
   logic        data_valid_rx;
   logic [7:0]  data_rx;
   logic        data_valid_tx;
   logic [7:0]  data_tx;
   logic        data_ack_tx;

   modport master (
      output req_start, req_ipv4, data_valid_rx, data_rx, data_ack_tx,
      input  req_busy, resolved_valid, resolved_mac, timeout, data_valid_tx, data_tx
   );

   modport slave (
      input  req_start, req_ipv4, data_valid_rx, data_rx, data_ack_tx,
      output req_busy, resolved_valid, resolved_mac, timeout, data_valid_tx, data_tx
   );
endinterface

// File: rtl/arp_request.sv
// ARP initiator: broadcasts an ARP Request, parses RX for the matching Reply, with
// timeout/retry. Define ARP_REQUEST_PAD_EN to pad the TX frame to 60 bytes.
module arp_request #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic         i_clk,
   input  logic         i_aresetn,
   input  logic [47:0]  i_my_mac,
   input  logic [31:0]  i_my_ipv4,
   arp_request_if.slave io_arp
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
`ifdef ARP_REQUEST_PAD_EN
   localparam logic [5:0] TX_LAST = 6'd59;
`else
   localparam logic [5:0] TX_LAST = 6'd41;
`endif
   localparam logic [5:0] RX_LAST = 6'd41;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]    r_state;
   logic [5:0]    r_tx_idx;
   logic [31:0]   r_target;
   logic [RW-1:0] r_retry;
   logic [TW-1:0] r_tcnt;
   logic          r_resolved_valid;
   logic [47:0]   r_resolved_mac;
   logic          r_timeout;

   logic          r_rx_prev;
   logic          r_rx_active;
   logic [5:0]    r_rx_idx;
   logic [47:0]   r_rx_sha;

   logic          w_tx_valid;
   logic [7:0]    w_tx_byte;
   logic          w_rx_chk;
   logic [7:0]    w_rx_exp;
   logic          w_rx_ok;
   logic          w_match;

   function automatic logic [7:0] f_mac_byte(input logic [47:0] mac, input logic [2:0] k);
      logic [7:0] b;
      case (k)
         3'd0:    b = mac[47:40];
         3'd1:    b = mac[39:32];
         3'd2:    b = mac[31:24];
         3'd3:    b = mac[23:16];
         3'd4:    b = mac[15:8];
         3'd5:    b = mac[7:0];
         default: b = '0;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] f_ip_byte(input logic [31:0] ip, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = ip[31:24];
         2'd1:    b = ip[23:16];
         2'd2:    b = ip[15:8];
         default: b = ip[7:0];
      endcase
      return b;
   endfunction

   // EtherType through OP (frame bytes 12..21); only the OP low byte differs between directions.
   function automatic logic [7:0] f_hdr_byte(input logic [3:0] k, input logic [7:0] op);
      logic [7:0] b;
      case (k)
         4'd0:    b = 8'h08;
         4'd1:    b = 8'h06;
         4'd2:    b = 8'h00;
         4'd3:    b = 8'h01;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h00;
         4'd6:    b = 8'h06;
         4'd7:    b = 8'h04;
         4'd8:    b = 8'h00;
         4'd9:    b = op;
         default: b = '0;
      endcase
      return b;
   endfunction

   assign w_tx_valid = (r_state == ST_SEND);

   always_comb begin
      w_tx_byte = '0;
      if (r_tx_idx <= 6'd5)
         w_tx_byte = 8'hFF;
      else if (r_tx_idx <= 6'd11)
         w_tx_byte = f_mac_byte(i_my_mac, 3'(r_tx_idx - 6'd6));
      else if (r_tx_idx <= 6'd21)
         w_tx_byte = f_hdr_byte(4'(r_tx_idx - 6'd12), 8'h01);
      else if (r_tx_idx <= 6'd27)
         w_tx_byte = f_mac_byte(i_my_mac, 3'(r_tx_idx - 6'd22));
      else if (r_tx_idx <= 6'd31)
         w_tx_byte = f_ip_byte(i_my_ipv4, 2'(r_tx_idx - 6'd28));
      else if (r_tx_idx >= 6'd38 && r_tx_idx <= 6'd41)
         w_tx_byte = f_ip_byte(r_target, 2'(r_tx_idx - 6'd38));
   end

   // Expected RX byte at the current parser position; MACs of the Ethernet header and SHA are don't-care.
   always_comb begin
      w_rx_chk = 1'b1;
      w_rx_exp = '0;
      if (r_rx_idx <= 6'd11)
         w_rx_chk = 1'b0;
      else if (r_rx_idx <= 6'd21)
         w_rx_exp = f_hdr_byte(4'(r_rx_idx - 6'd12), 8'h02);
      else if (r_rx_idx <= 6'd27)
         w_rx_chk = 1'b0;
      else if (r_rx_idx <= 6'd31)
         w_rx_exp = f_ip_byte(r_target, 2'(r_rx_idx - 6'd28));
      else if (r_rx_idx <= 6'd37)
         w_rx_exp = f_mac_byte(i_my_mac, 3'(r_rx_idx - 6'd32));
      else if (r_rx_idx <= 6'd41)
         w_rx_exp = f_ip_byte(i_my_ipv4, 2'(r_rx_idx - 6'd38));
      else
         w_rx_chk = 1'b0;
   end

   assign w_rx_ok = !w_rx_chk || (io_arp.data_rx == w_rx_exp);
   assign w_match = r_rx_active && io_arp.data_valid_rx && (r_rx_idx == RX_LAST) && w_rx_ok;

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_rx_prev   <= 1'b0;
         r_rx_active <= 1'b0;
         r_rx_idx    <= '0;
         r_rx_sha    <= '0;
      end else begin
         r_rx_prev <= io_arp.data_valid_rx;
         if (io_arp.data_valid_rx && !r_rx_prev) begin
            r_rx_active <= 1'b1;
            r_rx_idx    <= 6'd1;
         end else if (r_rx_active) begin
            if (!io_arp.data_valid_rx || !w_rx_ok || r_rx_idx == RX_LAST)
               r_rx_active <= 1'b0;
            else
               r_rx_idx <= r_rx_idx + 6'd1;
            if (io_arp.data_valid_rx && r_rx_idx >= 6'd22 && r_rx_idx <= 6'd27)
               r_rx_sha <= {r_rx_sha[39:0], io_arp.data_rx};
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_state          <= ST_IDLE;
         r_tx_idx         <= '0;
         r_target         <= '0;
         r_retry          <= '0;
         r_tcnt           <= '0;
         r_resolved_valid <= 1'b0;
         r_resolved_mac   <= '0;
         r_timeout        <= 1'b0;
      end else begin
         r_resolved_valid <= 1'b0;
         r_timeout        <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (io_arp.req_start) begin
                  r_target <= io_arp.req_ipv4;
                  r_retry  <= '0;
                  r_tx_idx <= '0;
                  r_state  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (r_tx_idx == 6'd0) begin
                  if (io_arp.data_ack_tx)
                     r_tx_idx <= 6'd1;
               end else if (r_tx_idx == TX_LAST) begin
                  r_tcnt  <= '0;
                  r_state <= ST_WAIT;
               end else begin
                  r_tx_idx <= r_tx_idx + 6'd1;
               end
            end
            ST_WAIT: begin
               // A match on the expiry cycle takes priority over retry/give-up.
               if (w_match) begin
                  r_resolved_valid <= 1'b1;
                  r_resolved_mac   <= r_rx_sha;
                  r_state          <= ST_IDLE;
               end else if (r_tcnt == T_LAST) begin
                  if (r_retry == R_MAX) begin
                     r_timeout <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_retry  <= r_retry + 1'b1;
                     r_tx_idx <= '0;
                     r_state  <= ST_SEND;
                  end
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io_arp.req_busy       = (r_state != ST_IDLE);
   assign io_arp.resolved_valid = r_resolved_valid;
   assign io_arp.resolved_mac   = r_resolved_mac;
   assign io_arp.timeout        = r_timeout;
   assign io_arp.data_valid_tx  = w_tx_valid;
   assign io_arp.data_tx        = w_tx_valid ? w_tx_byte : '0;

endmodule

// File: tb/tb_arp_request.sv
// Directed bench for arp_request: TX framing, reply matching, retry/timeout, async reset.
module tb_arp_request;
   localparam int unsigned T_CYC = 100;
   localparam int unsigned MAX_R = 2;
`ifdef ARP_REQUEST_PAD_EN
   localparam int LEN = 60;
`else
   localparam int LEN = 42;
`endif
   localparam logic [335:0] EXP_HDR = {48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 16'h0806, 16'h0001,
                                       16'h0800, 8'h06, 8'h04, 16'h0001, 48'h0A0B0C0D0E0F,
                                       32'hC0A80105, 48'h000000000000, 32'hC0A8010A};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] my_mac = 48'h0A0B0C0D0E0F;
   logic [31:0] my_ip = 32'hC0A80105;
   int checks = 0;
   int failures = 0;

   arp_request_if u_if();

   arp_request #(.TIMEOUT_CYCLES(T_CYC), .MAX_RETRIES(MAX_R)) u_dut (
      .i_clk(clk), .i_aresetn(rst_n), .i_my_mac(my_mac), .i_my_ipv4(my_ip), .io_arp(u_if)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_byte(input int i);
      logic [335:0] v;
      v = EXP_HDR;
      if (i < 42) return v[8*(41-i) +: 8];
      return 8'h00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      u_if.req_start = 1'b0;
      u_if.data_valid_rx = 1'b0;
      u_if.data_rx = 8'h00;
      u_if.data_ack_tx = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic start_req(input logic [31:0] ip);
      u_if.req_ipv4 = ip;
      u_if.req_start = 1'b1;
      tick();
      u_if.req_start = 1'b0;
   endtask

   task automatic skip_frame();
      for (int n = 0; n < 100 && u_if.data_valid_tx === 1'b1; n++) tick();
   endtask

   task automatic send_reply(input logic [47:0] sha, input logic [31:0] spa, input logic [7:0] op_lo,
                             input int nbytes, output logic saw_rv);
      logic [7:0] f [42];
      for (int k = 0; k < 6; k++) begin
         f[k] = my_mac[8*(5-k) +: 8];
         f[6+k] = sha[8*(5-k) +: 8];
         f[22+k] = sha[8*(5-k) +: 8];
         f[32+k] = my_mac[8*(5-k) +: 8];
      end
      f[12] = 8'h08; f[13] = 8'h06; f[14] = 8'h00; f[15] = 8'h01; f[16] = 8'h08;
      f[17] = 8'h00; f[18] = 8'h06; f[19] = 8'h04; f[20] = 8'h00; f[21] = op_lo;
      for (int k = 0; k < 4; k++) begin
         f[28+k] = spa[8*(3-k) +: 8];
         f[38+k] = my_ip[8*(3-k) +: 8];
      end
      saw_rv = 1'b0;
      u_if.data_valid_rx = 1'b0;
      tick();
      if (u_if.resolved_valid === 1'b1) saw_rv = 1'b1;
      for (int i = 0; i < nbytes; i++) begin
         u_if.data_valid_rx = 1'b1;
         u_if.data_rx = f[i];
         tick();
         if (u_if.resolved_valid === 1'b1) saw_rv = 1'b1;
      end
      u_if.data_valid_rx = 1'b0;
      u_if.data_rx = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (u_if.req_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", u_if.req_busy); end
      checks++; if (u_if.resolved_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", u_if.resolved_valid); end
      checks++; if (u_if.resolved_mac !== 48'h0) begin failures++; $display("FAIL reset_mac got=%h exp=0", u_if.resolved_mac); end
      checks++; if (u_if.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", u_if.timeout); end
      checks++; if (u_if.data_valid_tx !== 1'b0) begin failures++; $display("FAIL reset_valid_tx got=%b exp=0", u_if.data_valid_tx); end
      checks++; if (u_if.data_tx !== 8'h00) begin failures++; $display("FAIL reset_data_tx got=%h exp=00", u_if.data_tx); end
      #3 rst_n = 1'b1;
      repeat (3) tick();
      checks++; if (u_if.data_valid_tx !== 1'b0) begin failures++; $display("FAIL idle_no_tx got=%b exp=0", u_if.data_valid_tx); end
   endtask

   task automatic test_tx_frame();
      start_req(32'hC0A8010A);
      u_if.req_ipv4 = 32'hDEADBEEF;
      checks++; if (u_if.req_busy !== 1'b1) begin failures++; $display("FAIL tx_busy got=%b exp=1", u_if.req_busy); end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (u_if.data_valid_tx !== 1'b1 || u_if.data_tx !== 8'hFF) begin
            failures++; $display("FAIL tx_ff_hold cycle=%0d got valid=%b data=%h exp valid=1 data=ff", c, u_if.data_valid_tx, u_if.data_tx);
         end
         if (c == 3) u_if.data_ack_tx = 1'b1;
         tick();
      end
      u_if.data_ack_tx = 1'b0;
      for (int i = 1; i < LEN; i++) begin
         checks++;
         if (u_if.data_valid_tx !== 1'b1 || u_if.data_tx !== exp_byte(i)) begin
            failures++; $display("FAIL tx_byte idx=%0d got valid=%b data=%h exp valid=1 data=%h", i, u_if.data_valid_tx, u_if.data_tx, exp_byte(i));
         end
         tick();
      end
      checks++; if (u_if.data_valid_tx !== 1'b0) begin failures++; $display("FAIL tx_end_valid got=%b exp=0", u_if.data_valid_tx); end
      checks++; if (u_if.req_busy !== 1'b1) begin failures++; $display("FAIL tx_wait_busy got=%b exp=1", u_if.req_busy); end
   endtask

   task automatic test_resolve();
      logic saw;
      send_reply(48'h112233445566, 32'hC0A8010A, 8'h02, 42, saw);
      checks++; if (u_if.resolved_valid !== 1'b1) begin failures++; $display("FAIL resolve_rv got=%b exp=1", u_if.resolved_valid); end
      checks++; if (u_if.resolved_mac !== 48'h112233445566) begin failures++; $display("FAIL resolve_mac got=%h exp=112233445566", u_if.resolved_mac); end
      checks++; if (u_if.req_busy !== 1'b0) begin failures++; $display("FAIL resolve_busy got=%b exp=0", u_if.req_busy); end
      checks++; if (u_if.timeout !== 1'b0) begin failures++; $display("FAIL resolve_timeout got=%b exp=0", u_if.timeout); end
      start_req(32'hC0A8010A);
      checks++; if (u_if.resolved_valid !== 1'b0) begin failures++; $display("FAIL rv_pulse got=%b exp=0", u_if.resolved_valid); end
      checks++;
      if (u_if.req_busy !== 1'b1 || u_if.data_valid_tx !== 1'b1 || u_if.data_tx !== 8'hFF) begin
         failures++; $display("FAIL back_to_back got busy=%b valid=%b data=%h exp 1 1 ff", u_if.req_busy, u_if.data_valid_tx, u_if.data_tx);
      end
   endtask

   task automatic test_reset_mid_tx();
      logic saw_tx;
      u_if.data_ack_tx = 1'b1;
      repeat (20) tick();
      checks++;
      if (u_if.data_valid_tx !== 1'b1 || u_if.data_tx !== exp_byte(20)) begin
         failures++; $display("FAIL mid_tx_byte20 got valid=%b data=%h exp valid=1 data=%h", u_if.data_valid_tx, u_if.data_tx, exp_byte(20));
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (u_if.data_valid_tx !== 1'b0) begin failures++; $display("FAIL async_valid_tx got=%b exp=0", u_if.data_valid_tx); end
      checks++;
      if (u_if.req_busy !== 1'b0 || u_if.resolved_valid !== 1'b0 || u_if.timeout !== 1'b0 || u_if.data_tx !== 8'h00) begin
         failures++; $display("FAIL async_outputs got busy=%b rv=%b to=%b data=%h exp 0 0 0 00", u_if.req_busy, u_if.resolved_valid, u_if.timeout, u_if.data_tx);
      end
      checks++; if (u_if.resolved_mac !== 48'h0) begin failures++; $display("FAIL async_mac got=%h exp=0", u_if.resolved_mac); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      saw_tx = 1'b0;
      for (int n = 0; n < 150; n++) begin
         tick();
         if (u_if.data_valid_tx !== 1'b0) saw_tx = 1'b1;
      end
      checks++; if (saw_tx !== 1'b0) begin failures++; $display("FAIL post_reset_silent got=%b exp=0", saw_tx); end
      start_req(32'hC0A8010A);
      checks++;
      if (u_if.data_valid_tx !== 1'b1 || u_if.data_tx !== 8'hFF) begin
         failures++; $display("FAIL post_reset_start got valid=%b data=%h exp 1 ff", u_if.data_valid_tx, u_if.data_tx);
      end
   endtask

   task automatic test_retry_timeout();
      int n, bad, gap;
      do_reset();
      u_if.data_ack_tx = 1'b1;
      start_req(32'hC0A8010A);
      for (int a = 0; a < 3; a++) begin
         n = 0; bad = 0;
         while (u_if.data_valid_tx === 1'b1 && n < 100) begin
            if (u_if.data_tx !== exp_byte(n)) bad++;
            n++;
            tick();
         end
         checks++; if (n != LEN) begin failures++; $display("FAIL retry_len attempt=%0d got=%0d exp=%0d", a, n, LEN); end
         checks++; if (bad != 0) begin failures++; $display("FAIL retry_bytes attempt=%0d bad=%0d exp=0", a, bad); end
         gap = 0;
         while (u_if.data_valid_tx !== 1'b1 && u_if.timeout !== 1'b1 && gap < 300) begin
            if (a == 0 && gap == 10) begin
               u_if.req_ipv4 = 32'h01020304;
               u_if.req_start = 1'b1;
            end else begin
               u_if.req_start = 1'b0;
            end
            gap++;
            tick();
         end
         u_if.req_start = 1'b0;
         checks++; if (gap != T_CYC) begin failures++; $display("FAIL retry_gap attempt=%0d got=%0d exp=%0d", a, gap, T_CYC); end
         if (a < 2) begin
            checks++;
            if (u_if.data_valid_tx !== 1'b1 || u_if.timeout !== 1'b0) begin
               failures++; $display("FAIL retransmit attempt=%0d got valid=%b to=%b exp 1 0", a, u_if.data_valid_tx, u_if.timeout);
            end
         end else begin
            checks++;
            if (u_if.timeout !== 1'b1 || u_if.req_busy !== 1'b0 || u_if.data_valid_tx !== 1'b0) begin
               failures++; $display("FAIL timeout_pulse got to=%b busy=%b valid=%b exp 1 0 0", u_if.timeout, u_if.req_busy, u_if.data_valid_tx);
            end
         end
      end
      tick();
      checks++;
      if (u_if.timeout !== 1'b0 || u_if.data_valid_tx !== 1'b0) begin
         failures++; $display("FAIL timeout_one_cycle got to=%b valid=%b exp 0 0", u_if.timeout, u_if.data_valid_tx);
      end
   endtask

   task automatic test_bad_replies();
      logic saw;
      int n;
      do_reset();
      u_if.data_ack_tx = 1'b1;
      start_req(32'hC0A8010A);
      skip_frame();
      send_reply(48'hA1B2C3D4E5F6, 32'hC0A8010A, 8'h01, 42, saw);
      checks++; if (saw !== 1'b0) begin failures++; $display("FAIL bad_op got rv=%b exp=0", saw); end
      send_reply(48'hA1B2C3D4E5F6, 32'hC0A8010B, 8'h02, 42, saw);
      checks++; if (saw !== 1'b0) begin failures++; $display("FAIL bad_spa got rv=%b exp=0", saw); end
      n = 0;
      while (u_if.data_valid_tx !== 1'b1 && n < 300) begin n++; tick(); end
      checks++; if (u_if.data_valid_tx !== 1'b1) begin failures++; $display("FAIL bad_retx got valid=%b exp=1", u_if.data_valid_tx); end
      skip_frame();
      send_reply(48'hA1B2C3D4E5F6, 32'hC0A8010A, 8'h02, 30, saw);
      checks++;
      if (saw !== 1'b0 || u_if.req_busy !== 1'b1) begin
         failures++; $display("FAIL truncated got rv=%b busy=%b exp 0 1", saw, u_if.req_busy);
      end
      send_reply(48'hA1B2C3D4E5F6, 32'hC0A8010A, 8'h02, 42, saw);
      checks++;
      if (u_if.resolved_valid !== 1'b1 || u_if.resolved_mac !== 48'hA1B2C3D4E5F6) begin
         failures++; $display("FAIL good_after_bad got rv=%b mac=%h exp 1 a1b2c3d4e5f6", u_if.resolved_valid, u_if.resolved_mac);
      end
   endtask

   task automatic test_match_on_expiry();
      logic saw, late;
      do_reset();
      u_if.data_ack_tx = 1'b1;
      start_req(32'hC0A8010A);
      skip_frame();
      repeat (57) tick();
      send_reply(48'h665544332211, 32'hC0A8010A, 8'h02, 42, saw);
      checks++;
      if (u_if.resolved_valid !== 1'b1 || u_if.timeout !== 1'b0 || u_if.data_valid_tx !== 1'b0 || u_if.req_busy !== 1'b0) begin
         failures++; $display("FAIL expiry_match got rv=%b to=%b valid=%b busy=%b exp 1 0 0 0", u_if.resolved_valid, u_if.timeout, u_if.data_valid_tx, u_if.req_busy);
      end
      checks++; if (u_if.resolved_mac !== 48'h665544332211) begin failures++; $display("FAIL expiry_mac got=%h exp=665544332211", u_if.resolved_mac); end
      late = 1'b0;
      for (int n = 0; n < 120; n++) begin
         tick();
         if (u_if.data_valid_tx !== 1'b0 || u_if.timeout !== 1'b0) late = 1'b1;
      end
      checks++; if (late !== 1'b0) begin failures++; $display("FAIL expiry_no_retx got=%b exp=0", late); end
   endtask

   initial begin
      u_if.req_start = 1'b0;
      u_if.req_ipv4 = 32'h0;
      u_if.data_valid_rx = 1'b0;
      u_if.data_rx = 8'h00;
      u_if.data_ack_tx = 1'b0;
      test_reset();
      test_tx_frame();
      test_resolve();
      test_reset_mid_tx();
      test_retry_timeout();
      test_bad_replies();
      test_match_on_expiry();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
